// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BRK_WAIT
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_interface.sv
// UART line/word bundle; rxif faces the receiver, txif faces the transmitter.
interface uart_interface #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  signal;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport rxif (input signal, output data, output valid, output ready);
  modport txif (output signal, input data, input valid, output ready);
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for asynchronous single-bit inputs.
module uart_sync #(
  parameter int unsigned DEPTH     = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= {DEPTH{RESET_VAL}};
    else     ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];

  if (DEPTH < 2) begin : g_depth_check
    $fatal(1, "uart_sync: DEPTH must be at least 2");
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling deserialiser with optional parity and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter parity_t     PARITY     = PAR_NONE
) (
  input  logic        clk,
  input  logic        rst,
  uart_interface.rxif rx,
  output logic        frame_err,
  output logic        parity_err
);

  localparam int unsigned C  = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned H  = C / 2;
  localparam int unsigned TW = $clog2(C);
  localparam int unsigned IW = $clog2(DATA_WIDTH);

  if (C < 4 || DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_param_check
    $fatal(1, "uart_rx: need CLK_FREQ/BAUD_RATE >= 4 and DATA_WIDTH in 5..9");
  end

  logic                  s;
  rx_state_t             state;
  logic [TW-1:0]         timer;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ready_q;

  uart_sync #(.DEPTH(2), .RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx.signal),
    .q   (s)
  );

  // Timer counts down to zero, so it is loaded with (interval - 1) and fits in $clog2(C) bits.
  always_ff @(posedge clk) begin
    valid_q <= 1'b0;
    if (rst) begin
      state      <= RX_IDLE;
      timer      <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_err_q  <= 1'b0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          ready_q <= 1'b1;
          if (!s) begin
            state     <= RX_START;
            timer     <= TW'(H - 1);
            par_err_q <= 1'b0;
            ready_q   <= 1'b0;
          end
        end
        RX_START: begin
          if (timer == '0) begin
            if (s) begin
              state   <= RX_IDLE;
              ready_q <= 1'b1;
            end else begin
              state <= RX_DATA;
              timer <= TW'(C - 1);
              idx   <= '0;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        RX_DATA: begin
          if (timer == '0) begin
            shreg <= {s, shreg[DATA_WIDTH-1:1]};
            timer <= TW'(C - 1);
            if (idx == IW'(DATA_WIDTH - 1))
              state <= (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
            else
              idx <= idx + IW'(1);
          end else begin
            timer <= timer - TW'(1);
          end
        end
        RX_PARITY: begin
          if (timer == '0) begin
            par_err_q <= ((^shreg) ^ s) != (PARITY == PAR_ODD);
            timer     <= TW'(C - 1);
            state     <= RX_STOP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        RX_STOP: begin
          if (timer == '0) begin
            data_q     <= shreg;
            valid_q    <= 1'b1;
            frame_err  <= ~s;
            parity_err <= (PARITY != PAR_NONE) && par_err_q;
            // Exit at mid-stop-bit so a start edge in the next half-bit is still caught.
            if (s) begin
              state   <= RX_IDLE;
              ready_q <= 1'b1;
            end else begin
              state <= RX_BRK_WAIT;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        RX_BRK_WAIT: begin
          if (s) begin
            state   <= RX_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= RX_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.data  = data_q;
  assign rx.valid = valid_q;
  assign rx.ready = ready_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model predicts each valid pulse; directed scenarios at C = 16.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C = 16;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line_n = 1'b1;
  logic line_e = 1'b1;
  logic fe_n, pe_n, fe_e, pe_e;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int         dut;
    int         cyc;
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } ev_t;

  ev_t        evq[$];
  int         vt0[$];
  logic [7:0] last_data[2];
  logic [7:0] last_vdata[2];
  logic       last_fe[2];
  logic       last_pe[2];
  int         last_vtime[2];
  int         nvalid[2];

  uart_interface #(.DATA_WIDTH(8)) ifn ();
  uart_interface #(.DATA_WIDTH(8)) ife ();
  assign ifn.signal = line_n;
  assign ife.signal = line_e;

  uart_rx #(.DATA_WIDTH(8), .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY(PAR_NONE)) dut_n (
    .clk(clk), .rst(rst), .rx(ifn), .frame_err(fe_n), .parity_err(pe_n)
  );
  uart_rx #(.DATA_WIDTH(8), .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY(PAR_EVEN)) dut_e (
    .clk(clk), .rst(rst), .rx(ife), .frame_err(fe_e), .parity_err(pe_e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_dut(input int d, input logic v, input logic [7:0] dat, input logic fe, input logic pe);
    int idx;
    idx = -1;
    foreach (evq[i]) if (idx < 0 && evq[i].dut == d) idx = i;
    if (v === 1'b1) begin
      nvalid[d]++;
      last_vtime[d] = cyc;
      last_vdata[d] = dat;
      last_fe[d]    = fe;
      last_pe[d]    = pe;
      if (d == 0) vt0.push_back(cyc);
      if (idx < 0 || evq[idx].cyc != cyc) begin
        tests++;
        fails++;
        $display("FAIL valid_time dut%0d: valid at cycle %0d, expected cycle %0d",
                 d, cyc, (idx < 0) ? -1 : evq[idx].cyc);
      end else begin
        check($sformatf("data dut%0d", d), dat, evq[idx].data);
        check($sformatf("frame_err dut%0d", d), fe, evq[idx].fe);
        check($sformatf("parity_err dut%0d", d), pe, evq[idx].pe);
        last_data[d] = evq[idx].data;
        evq.delete(idx);
      end
    end else begin
      check($sformatf("valid_low dut%0d", d), v, 0);
      if (idx >= 0 && evq[idx].cyc == cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_valid dut%0d: no valid at cycle %0d, expected one", d, cyc);
        last_data[d] = evq[idx].data;
        evq.delete(idx);
      end
      check($sformatf("data_hold dut%0d", d), dat, last_data[d]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk_dut(0, ifn.valid, ifn.data, fe_n, pe_n);
      chk_dut(1, ife.valid, ife.data, fe_e, pe_e);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int d, input logic b);
    if (d == 0) line_n = b;
    else        line_e = b;
    tick(C);
  endtask

  // Caller is always #1 after a clock edge; expected valid = fall + 2 (sync) + H + bits*C + 1.
  task automatic send_frame(input int d, input logic [7:0] data, input bit has_par,
                            input logic par_bit, input logic stop_bit, output int fall);
    ev_t e;
    fall   = cyc;
    e.dut  = d;
    e.cyc  = cyc + 2 + H + (9 + (has_par ? 1 : 0)) * C + 1;
    e.data = data;
    e.fe   = ~stop_bit;
    e.pe   = has_par && (par_bit != ^data);
    evq.push_back(e);
    put(d, 1'b0);
    for (int i = 0; i < 8; i++) put(d, data[i]);
    if (has_par) put(d, par_bit);
    put(d, stop_bit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fall, k, nv;
    logic [7:0] frame_5a;

    tick(1);
    check("rst data_n", ifn.data, 0);
    check("rst valid_n", ifn.valid, 0);
    check("rst ready_n", ifn.ready, 0);
    check("rst frame_err_n", fe_n, 0);
    check("rst parity_err_n", pe_n, 0);
    check("rst data_e", ife.data, 0);
    check("rst ready_e", ife.ready, 0);
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;
    nvalid[0] = 0;
    nvalid[1] = 0;
    rst = 1'b0;
    chk_en = 1'b1;
    tick(1);
    check("ready after reset n", ifn.ready, 1);
    check("ready after reset e", ife.ready, 1);
    tick(2 * C);

    // Even parity: 0x37 has five ones, so the correct parity bit is 1.
    send_frame(1, 8'h37, 1'b1, 1'b0, 1'b1, fall);
    tick(C);
    check("par_bad valid time", last_vtime[1], fall + 171);
    check("par_bad data", last_vdata[1], 8'h37);
    check("par_bad parity_err", last_pe[1], 1);
    check("par_bad frame_err", last_fe[1], 0);
    send_frame(1, 8'h37, 1'b1, 1'b1, 1'b1, fall);
    tick(C);
    check("par_ok parity_err", last_pe[1], 0);
    check("par_ok count", nvalid[1], 2);
    tick(2 * C);

    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, fall);
    check("a5 valid time", last_vtime[0], fall + 155);
    check("a5 data", last_vdata[0], 8'hA5);
    check("a5 frame_err", last_fe[0], 0);
    check("a5 parity_err", last_pe[0], 0);
    check("a5 ready", ifn.ready, 1);
    check("a5 count", nvalid[0], 1);
    tick(2 * C);

    nv = nvalid[0];
    k = cyc;
    line_n = 1'b0;
    tick(5);
    line_n = 1'b1;
    check("glitch ready busy", ifn.ready, 0);
    tick(5);
    check("glitch ready before T+9", ifn.ready, 0);
    tick(1);
    check("glitch ready at T+9", ifn.ready, 1);
    check("glitch cycle", cyc - k, 11);
    tick(2 * C);
    check("glitch no valid", nvalid[0], nv);

    nv = nvalid[0];
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, fall);
    tick(40 * C);
    check("break ready low", ifn.ready, 0);
    line_n = 1'b1;
    tick(2);
    check("break ready before release", ifn.ready, 0);
    tick(1);
    check("break ready after release", ifn.ready, 1);
    check("break one valid", nvalid[0], nv + 1);
    check("break frame_err", last_fe[0], 1);
    check("break data", last_vdata[0], 8'h3C);
    tick(3 * C);

    nv = nvalid[0];
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, fall);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, fall);
    tick(C);
    check("b2b count", nvalid[0], nv + 2);
    if (vt0.size() >= 2) check("b2b spacing", vt0[vt0.size() - 1] - vt0[vt0.size() - 2], 160);
    else check("b2b spacing present", vt0.size(), 2);
    check("b2b second data", last_vdata[0], 8'hFF);
    tick(2 * C);

    // Partial 0x5A frame (bit 4 = 1), reset in the middle of data bit 4.
    nv = nvalid[0];
    frame_5a = 8'h5A;
    put(0, 1'b0);
    for (int i = 0; i < 4; i++) put(0, frame_5a[i]);
    line_n = frame_5a[4];
    tick(8);
    rst = 1'b1;
    tick(1);
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;
    check("midrst data_n", ifn.data, 0);
    check("midrst ready_n", ifn.ready, 0);
    check("midrst valid_n", ifn.valid, 0);
    check("midrst data_e", ife.data, 0);
    rst = 1'b0;
    tick(1);
    check("midrst ready rises", ifn.ready, 1);
    tick(20 * C);
    check("midrst no valid", nvalid[0], nv);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, fall);
    tick(C);
    check("post-reset count", nvalid[0], nv + 1);
    check("post-reset data", last_vdata[0], 8'h5A);
    check("post-reset frame_err", last_fe[0], 0);
    tick(2 * C);

    check("no pending frames", evq.size(), 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
